aes_round_key_buffer: RTL and testbench

- Sits directly downstream of the iterative AES-128 key expansion stage.
- Captures the cipher key as round key 0 and the ten expanded round keys, one per cycle, into an 11-entry register store.
- Replays the stored keys one per cycle to the cipher round datapath, in ascending order (encryption) or descending order (decryption), with a hold input for stalls.
- The schedule is computed once per key load and reused for any number of blocks.

---
 rtl/aes_round_key_buffer.sv | 142 ++++++++++++++
 tb/tb_aes_round_key_buffer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_key_buffer.sv
// Purpose : captures an AES-128 key schedule (cipher key + NR expanded keys) and replays it, ascending or descending.
// Latency : 1 cycle from rd_req_i to the first key; then one key per cycle, outputs registered.
// Backpressure: rd_hold_i freezes the replay output and index; load_i aborts any activity and restarts capture.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), asynchronous active-low reset
//   load_i, key_i            start a schedule capture; key_i becomes round key 0
//   exp_valid_i, exp_key_i   expanded round keys 1..NR from the key expansion stage
//   rd_req_i, rd_dec_i       start a replay; rd_dec_i selects descending order
//   rd_hold_i                stall the replay
//   rd_valid_o, rd_key_o,
//   rd_round_o, rd_last_o    replayed key, its index and final-key flag
//   ready_o, busy_o          schedule stored and idle / capture or replay in progress
module aes_round_key_buffer #(
    parameter int KW = 128,
    parameter int NR = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [KW-1:0] key_i,
    input  logic          exp_valid_i,
    input  logic [KW-1:0] exp_key_i,
    input  logic          rd_req_i,
    input  logic          rd_dec_i,
    input  logic          rd_hold_i,
    output logic          rd_valid_o,
    output logic [KW-1:0] rd_key_o,
    output logic [3:0]    rd_round_o,
    output logic          rd_last_o,
    output logic          ready_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        READY  = 2'd2,
        STREAM = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NR);

    // Key store: deliberately not reset, it is only observable once ready_o is set.
    logic [KW-1:0] rk [0:NR];

    state_t     state;
    logic [3:0] fill_cnt;
    logic       dec;

    logic [3:0] start_idx;
    logic [3:0] start_end_idx;
    logic [3:0] next_idx;
    logic [3:0] end_idx;

    // rd_round_o doubles as the replay index; next/end depend on the direction latched at request.
    always_comb begin
        start_idx     = rd_dec_i ? LAST_IDX : 4'd0;
        start_end_idx = rd_dec_i ? 4'd0 : LAST_IDX;
        next_idx      = dec ? (rd_round_o - 4'd1) : (rd_round_o + 4'd1);
        end_idx       = dec ? 4'd0 : LAST_IDX;
    end

    // load_i is honoured in every state, so the cipher key write does not depend on state.
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            rk[0] <= key_i;
        end else if (state == FILL && exp_valid_i) begin
            rk[fill_cnt] <= exp_key_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            fill_cnt   <= 4'd0;
            dec        <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_key_o   <= '0;
            rd_round_o <= 4'd0;
            rd_last_o  <= 1'b0;
            ready_o    <= 1'b0;
            busy_o     <= 1'b0;
        end else if (load_i) begin
            // Restart capture from any state; an active replay is dropped, and a
            // coincident rd_req_i in READY is lost.
            state      <= FILL;
            fill_cnt   <= 4'd1;
            rd_valid_o <= 1'b0;
            rd_last_o  <= 1'b0;
            ready_o    <= 1'b0;
            busy_o     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // Nothing stored yet; requests and expansion data are ignored.
                end
                FILL: begin
                    if (exp_valid_i) begin
                        fill_cnt <= fill_cnt + 4'd1;
                        if (fill_cnt == LAST_IDX) begin
                            state   <= READY;
                            ready_o <= 1'b1;
                            busy_o  <= 1'b0;
                        end
                    end
                end
                READY: begin
                    if (rd_req_i) begin
                        state      <= STREAM;
                        ready_o    <= 1'b0;
                        busy_o     <= 1'b1;
                        dec        <= rd_dec_i;
                        rd_valid_o <= 1'b1;
                        rd_key_o   <= rk[start_idx];
                        rd_round_o <= start_idx;
                        rd_last_o  <= (start_idx == start_end_idx);
                    end
                end
                STREAM: begin
                    if (!rd_hold_i) begin
                        if (rd_last_o) begin
                            state      <= READY;
                            rd_valid_o <= 1'b0;
                            rd_last_o  <= 1'b0;
                            ready_o    <= 1'b1;
                            busy_o     <= 1'b0;
                        end else begin
                            rd_key_o   <= rk[next_idx];
                            rd_round_o <= next_idx;
                            rd_last_o  <= (next_idx == end_idx);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_key_buffer.sv
// Purpose : self-checking bench for aes_round_key_buffer using FIPS-197 key schedule vectors.
// Latency : stimulus pushes expected replay beats into a queue; a negedge monitor pops them.
// Backpressure: hold, abort, gapped fill and asynchronous reset scenarios are exercised.
module tb_aes_round_key_buffer;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         load_i;
    logic [127:0] key_i;
    logic         exp_valid_i;
    logic [127:0] exp_key_i;
    logic         rd_req_i;
    logic         rd_dec_i;
    logic         rd_hold_i;
    logic         rd_valid_o;
    logic [127:0] rd_key_o;
    logic [3:0]   rd_round_o;
    logic         rd_last_o;
    logic         ready_o;
    logic         busy_o;

    aes_round_key_buffer #(.KW(128), .NR(10)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (load_i),
        .key_i       (key_i),
        .exp_valid_i (exp_valid_i),
        .exp_key_i   (exp_key_i),
        .rd_req_i    (rd_req_i),
        .rd_dec_i    (rd_dec_i),
        .rd_hold_i   (rd_hold_i),
        .rd_valid_o  (rd_valid_o),
        .rd_key_o    (rd_key_o),
        .rd_round_o  (rd_round_o),
        .rd_last_o   (rd_last_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   round;
        logic         last;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [127:0] fips [0:10];
    logic [127:0] cur  [0:10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every valid output beat must match the head of the scoreboard.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && rd_valid_o === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got round %0d key %h, expected no output", rd_round_o, rd_key_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (rd_key_o !== e.key || rd_round_o !== e.round || rd_last_o !== e.last) begin
                    errors++;
                    $display("FAIL replay_beat: got round %0d last %0b key %h, expected round %0d last %0b key %h",
                             rd_round_o, rd_last_o, rd_key_o, e.round, e.last, e.key);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_replay(input logic dec, input int hold_round, input int count);
        for (int j = 0; j < count; j++) begin
            int r;
            int reps;
            exp_t e;
            r    = dec ? (10 - j) : j;
            reps = (r == hold_round) ? 4 : 1;
            for (int k = 0; k < reps; k++) begin
                e.key   = cur[r];
                e.round = 4'(r);
                e.last  = (r == (dec ? 0 : 10));
                sb_q.push_back(e);
            end
        end
    endtask

    // Issues a request and walks the replay while valid. hold_at: beat index at which
    // a 3-cycle hold begins (-1 none). stop_at: return while that beat is presented (-1 none).
    task automatic run_replay(input logic dec, input int hold_at, input int stop_at, output int n);
        rd_req_i = 1'b1;
        rd_dec_i = dec;
        step();
        rd_req_i = 1'b0;
        n = 0;
        while (rd_valid_o === 1'b1 && n < 40) begin
            if (n == stop_at) return;
            rd_hold_i = (hold_at >= 0 && n >= hold_at && n < hold_at + 3);
            step();
            n++;
        end
        rd_hold_i = 1'b0;
    endtask

    // Loads cur[0] and streams cur[1..10]; gapped inserts idle cycles and a stray request.
    task automatic fill(input logic gapped);
        load_i = 1'b1;
        key_i  = cur[0];
        step();
        load_i = 1'b0;
        chk("fill_busy", 128'(busy_o), 128'(1));
        for (int r = 1; r <= 10; r++) begin
            exp_valid_i = 1'b1;
            exp_key_i   = cur[r];
            step();
            exp_valid_i = 1'b0;
            chk($sformatf("fill_ready_r%0d", r), 128'(ready_o), 128'(r == 10));
            chk($sformatf("fill_valid_r%0d", r), 128'(rd_valid_o), 128'(0));
            if (gapped && r < 10) begin
                exp_key_i = ~cur[r];
                rd_req_i  = (r == 5);
                step();
                rd_req_i = 1'b0;
                chk($sformatf("gap_valid_r%0d", r), 128'(rd_valid_o), 128'(0));
                chk($sformatf("gap_ready_r%0d", r), 128'(ready_o), 128'(0));
            end
        end
        chk("fill_done_busy", 128'(busy_o), 128'(0));
    endtask

    initial begin
        int n;
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst_ni = 1'b0; load_i = 1'b0; key_i = '0; exp_valid_i = 1'b0; exp_key_i = '0;
        rd_req_i = 1'b0; rd_dec_i = 1'b0; rd_hold_i = 1'b0;
        #12;
        chk("rst_valid", 128'(rd_valid_o), 128'(0));
        chk("rst_ready", 128'(ready_o), 128'(0));
        chk("rst_busy",  128'(busy_o), 128'(0));
        chk("rst_last",  128'(rd_last_o), 128'(0));
        chk("rst_round", 128'(rd_round_o), 128'(0));
        chk("rst_key",   rd_key_o, 128'(0));
        rst_ni = 1'b1;
        step();

        // Requests and expansion data in IDLE are ignored.
        rd_req_i = 1'b1; exp_valid_i = 1'b1;
        step();
        rd_req_i = 1'b0; exp_valid_i = 1'b0;
        step();
        chk("idle_req_valid", 128'(rd_valid_o), 128'(0));
        chk("idle_busy", 128'(busy_o), 128'(0));

        // FIPS-197 fill, forward then reverse replay.
        for (int i = 0; i <= 10; i++) cur[i] = fips[i];
        fill(1'b0);
        push_replay(1'b0, -1, 11);
        run_replay(1'b0, -1, -1, n);
        chk("fwd_len", 128'(n), 128'(11));
        chk("fwd_ready_after", 128'(ready_o), 128'(1));
        chk("fwd_last_after", 128'(rd_last_o), 128'(0));

        push_replay(1'b1, -1, 11);
        run_replay(1'b1, -1, -1, n);
        chk("rev_len", 128'(n), 128'(11));
        chk("rev_busy_after", 128'(busy_o), 128'(0));

        // Hold round 4 for three extra cycles.
        push_replay(1'b0, 4, 11);
        run_replay(1'b0, 4, -1, n);
        chk("hold_len", 128'(n), 128'(14));

        // Gapped fill with bit-inverted data and a stray request mid-fill.
        for (int i = 0; i <= 10; i++) cur[i] = ~fips[i];
        fill(1'b1);
        push_replay(1'b0, -1, 11);
        run_replay(1'b0, -1, -1, n);
        chk("gap_fwd_len", 128'(n), 128'(11));

        // Abort at round 6 with load_i; new fill from rotated data, then reverse replay.
        push_replay(1'b0, -1, 7);
        run_replay(1'b0, -1, 6, n);
        chk("abort_round", 128'(rd_round_o), 128'(6));
        for (int i = 0; i <= 10; i++) cur[i] = {fips[i][63:0], fips[i][127:64]};
        load_i = 1'b1;
        key_i  = cur[0];
        step();
        load_i = 1'b0;
        chk("abort_valid", 128'(rd_valid_o), 128'(0));
        chk("abort_busy",  128'(busy_o), 128'(1));
        chk("abort_ready", 128'(ready_o), 128'(0));
        for (int r = 1; r <= 10; r++) begin
            exp_valid_i = 1'b1;
            exp_key_i   = cur[r];
            step();
        end
        exp_valid_i = 1'b0;
        chk("abort_refill_ready", 128'(ready_o), 128'(1));
        push_replay(1'b1, -1, 11);
        run_replay(1'b1, -1, -1, n);
        chk("abort_rev_len", 128'(n), 128'(11));

        // load_i with rd_req_i in READY: load wins, no replay.
        for (int i = 0; i <= 10; i++) cur[i] = fips[i];
        load_i = 1'b1; rd_req_i = 1'b1; key_i = cur[0];
        step();
        load_i = 1'b0; rd_req_i = 1'b0;
        chk("prio_valid", 128'(rd_valid_o), 128'(0));
        chk("prio_busy",  128'(busy_o), 128'(1));
        chk("prio_ready", 128'(ready_o), 128'(0));
        for (int r = 1; r <= 10; r++) begin
            exp_valid_i = 1'b1;
            exp_key_i   = cur[r];
            step();
        end
        exp_valid_i = 1'b0;
        chk("prio_refill_ready", 128'(ready_o), 128'(1));

        // Asynchronous reset mid-replay at round 3 (round 3 is never sampled by the monitor).
        push_replay(1'b0, -1, 3);
        run_replay(1'b0, -1, 3, n);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_valid", 128'(rd_valid_o), 128'(0));
        chk("arst_ready", 128'(ready_o), 128'(0));
        chk("arst_busy",  128'(busy_o), 128'(0));
        #2 rst_ni = 1'b1;
        rd_req_i = 1'b1;
        step();
        step();
        rd_req_i = 1'b0;
        chk("post_rst_valid", 128'(rd_valid_o), 128'(0));
        chk("post_rst_ready", 128'(ready_o), 128'(0));

        // Fresh fill after reset replays correctly.
        fill(1'b0);
        push_replay(1'b0, -1, 11);
        run_replay(1'b0, -1, -1, n);
        chk("post_rst_fwd_len", 128'(n), 128'(11));

        step();
        chk("scoreboard_empty", 128'(sb_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
